mod_sequencer: RTL and testbench

MOD_SEQUENCER -- requirements
Module: mod_sequencer

---
 rtl/mod_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_mod_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mod_sequencer
//  Description : Run/flush/hold sequencer for a PRBS source feeding a FIR.
//                Divides the clock into a one-cycle sample strobe (o_valid),
//                flushes the FIR for FLUSH_LEN strobes after every start,
//                then runs or holds under control of the synchronised
//                switches.  The state code and strobe appear on the LEDs.
//  Options     : MOD_SEQ_HEARTBEAT_EN - when defined, o_leds[3] becomes a
//                heartbeat that toggles every 256 strobes; otherwise
//                o_leds[3] mirrors o_prbs_enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_sequencer #(
    parameter int NB_COUNT  = 3,   // strobe divider width, period 2**NB_COUNT
    parameter int FLUSH_LEN = 8    // strobes spent flushing, 1..255
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [3:0] i_switch,
    output logic       o_valid,
    output logic       o_prbs_enable,
    output logic       o_fir_enable,
    output logic       o_prbs_rst,
    output logic       o_fir_rst,
    output logic [1:0] o_state,
    output logic [3:0] o_leds
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLUSH = 2'b01,
        ST_RUN   = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    // Flush count value carried by the final flush strobe.
    localparam logic [7:0]          C_FLUSH_LAST = 8'(FLUSH_LEN - 1);
    localparam logic [NB_COUNT-1:0] C_DIV_ONE    = NB_COUNT'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]          sw_meta_q;    // first synchroniser stage
    logic [1:0]          sw_q;         // synchronised switches: [0] run, [1] resume
    state_t              state_q;
    state_t              state_d;
    logic [NB_COUNT-1:0] div_q;        // strobe phase divider
    logic [NB_COUNT-1:0] div_d;
    logic [7:0]          flush_q;      // strobes seen during the current flush
    logic [7:0]          flush_d;
    logic                w_div_full;   // divider sits on its last phase
    logic                w_strobing;   // state in which the divider advances
    logic                w_flush_done; // last flush strobe is present this cycle
    logic                w_led3;
    logic                w_unused_sw;  // i_switch[3:2] are reserved

    assign w_unused_sw = ^i_switch[3:2];

    // ------------------------------------------------------------------------
    // Switch synchroniser
    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the run and resume switches.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            sw_meta_q <= 2'b00;
            sw_q      <= 2'b00;
        end else begin
            sw_meta_q <= i_switch[1:0];
            sw_q      <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Strobe generation
    // ------------------------------------------------------------------------
    assign w_div_full   = &div_q;
    assign w_strobing   = (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign o_valid      = w_div_full && w_strobing;
    assign w_flush_done = o_valid && (flush_q == C_FLUSH_LAST);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; dropping the run switch wins over everything else.
    always_comb begin
        state_d = state_q;
        if (!sw_q[0]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_flush_done) begin
                        state_d = sw_q[1] ? ST_RUN : ST_HOLD;
                    end
                end
                ST_RUN: begin
                    if (!sw_q[1]) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Resuming skips the flush; the divider phase was frozen.
                    if (sw_q[1]) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Divider and flush counter
    // ------------------------------------------------------------------------
    // Counter next values: divider advances while strobing, freezes in HOLD
    // and is zero whenever the machine is, or is about to be, in IDLE.
    always_comb begin
        div_d   = div_q;
        flush_d = 8'd0;
        case (state_q)
            ST_FLUSH, ST_RUN: div_d = div_q + C_DIV_ONE;
            ST_HOLD:          div_d = div_q;
            default:          div_d = '0;
        endcase
        if (state_d == ST_IDLE) begin
            div_d = '0;
        end
        // The flush count only lives while FLUSH persists across the edge,
        // so every fresh flush (including after an abort) starts from 0.
        if ((state_q == ST_FLUSH) && (state_d == ST_FLUSH)) begin
            flush_d = flush_q + {7'd0, o_valid};
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            div_q   <= '0;
            flush_q <= 8'd0;
        end else begin
            div_q   <= div_d;
            flush_q <= flush_d;
        end
    end

    // ------------------------------------------------------------------------
    // Enables, resets and status
    // ------------------------------------------------------------------------
    // Decode the datapath controls from the current state.  During FLUSH
    // the PRBS is stalled while the FIR keeps consuming its held bit.
    always_comb begin
        o_prbs_enable = 1'b0;
        o_fir_enable  = 1'b0;
        o_prbs_rst    = 1'b0;
        o_fir_rst     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_prbs_rst = 1'b1;
                o_fir_rst  = 1'b1;
            end
            ST_FLUSH: begin
                o_fir_enable = 1'b1;
            end
            ST_RUN: begin
                o_prbs_enable = 1'b1;
                o_fir_enable  = 1'b1;
            end
            default: begin
                o_prbs_enable = 1'b0;
                o_fir_enable  = 1'b0;
            end
        endcase
    end

    assign o_state = state_q;

`ifdef MOD_SEQ_HEARTBEAT_EN
    logic [7:0] hb_cnt_q;   // strobes since the last heartbeat toggle
    logic       hb_led_q;

    // Heartbeat: toggle the LED every 256 strobes; cleared with the state
    // machine so it reads 0 on every cycle spent in IDLE.
    always_ff @(posedge clock) begin
        if (!i_reset || (state_d == ST_IDLE)) begin
            hb_cnt_q <= 8'd0;
            hb_led_q <= 1'b0;
        end else if (o_valid) begin
            hb_cnt_q <= hb_cnt_q + 8'd1;
            if (hb_cnt_q == 8'hFF) begin
                hb_led_q <= ~hb_led_q;
            end
        end
    end

    assign w_led3 = hb_led_q;
`else
    assign w_led3 = o_prbs_enable;
`endif

    assign o_leds = {w_led3, state_q, o_valid};

endmodule
`default_nettype wire

// File: tb/tb_mod_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_sequencer
//  Description : Self-checking bench for mod_sequencer (NB_COUNT=3,
//                FLUSH_LEN=8).  Expected outputs are queued with the cycle
//                at which they must appear and compared as cycles elapse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_sequencer;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_switch = 4'b0000;
    logic       o_valid;
    logic       o_prbs_enable;
    logic       o_fir_enable;
    logic       o_prbs_rst;
    logic       o_fir_rst;
    logic [1:0] o_state;
    logic [3:0] o_leds;

    mod_sequencer #(
        .NB_COUNT  (3),
        .FLUSH_LEN (8)
    ) u_dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_switch      (i_switch),
        .o_valid       (o_valid),
        .o_prbs_enable (o_prbs_enable),
        .o_fir_enable  (o_fir_enable),
        .o_prbs_rst    (o_prbs_rst),
        .o_fir_rst     (o_fir_rst),
        .o_state       (o_state),
        .o_leds        (o_leds)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] observe(input int sig);
        case (sig)
            0:       return {2'b00, o_state};
            1:       return {3'b000, o_valid};
            2:       return {3'b000, o_prbs_enable};
            3:       return {3'b000, o_fir_enable};
            4:       return {2'b00, o_prbs_rst, o_fir_rst};
            default: return o_leds;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            0:       return "state";
            1:       return "valid";
            2:       return "prbs_en";
            3:       return "fir_en";
            4:       return "resets";
            default: return "leds";
        endcase
    endfunction

    // Queue the complete expected output set for absolute cycle c.
    task automatic push_abs(input int c, input logic [1:0] st, input logic v, input logic hb);
        logic prbs;
        logic fir;
        logic rsts;
        logic l3;
        prbs = (st == 2'b10);
        fir  = (st == 2'b01) || (st == 2'b10);
        rsts = (st == 2'b00);
`ifdef MOD_SEQ_HEARTBEAT_EN
        l3 = hb;
`else
        l3 = prbs | (hb & 1'b0);
`endif
        sb.push_back('{c, 0, {2'b00, st}});
        sb.push_back('{c, 1, {3'b000, v}});
        sb.push_back('{c, 2, {3'b000, prbs}});
        sb.push_back('{c, 3, {3'b000, fir}});
        sb.push_back('{c, 4, {2'b00, rsts, rsts}});
        sb.push_back('{c, 5, {l3, st, v}});
    endtask

    // A full flush: strobe on the 8th cycle of each period, 64 cycles long.
    task automatic push_flush(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            push_abs(base + k, 2'b01, (k % 8) == 7, 1'b0);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, settle due entries.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            e = sb.pop_front();
            check_val($sformatf("%s@%0d", sig_name(e.sig), e.cyc), {28'd0, observe(e.sig)}, {28'd0, e.val});
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: cycle %0d reached without completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int f;
        int r;
        int a;
        int f1;
        int g;
        int h;
        int j;
        int k0;

        // Reset held for three edges.
        for (int c = 1; c <= 3; c++) push_abs(c, 2'b00, 1'b0, 1'b0);
        run_to(3);
        i_reset = 1'b1;

        // Idle with switches off for 50 clocks.
        for (int c = 4; c <= 53; c++) push_abs(c, 2'b00, 1'b0, 1'b0);
        run_to(53);

        // Start with resume set: FLUSH three edges later, RUN 64 clocks on.
        i_switch = 4'b0011;
        f = cyc + 3;
        push_abs(cyc + 1, 2'b00, 1'b0, 1'b0);
        push_abs(cyc + 2, 2'b00, 1'b0, 1'b0);
        push_flush(f, 64);
        r = f + 64;
        // RUN from divider 0, hold from r+5 for 20 cycles with divider frozen
        // at 5, then resume strobing from that phase.
        for (int c = r; c <= r + 4; c++) push_abs(c, 2'b10, ((c - r) % 8) == 7, 1'b0);
        for (int c = r + 5; c <= r + 24; c++) push_abs(c, 2'b11, 1'b0, 1'b0);
        for (int c = r + 25; c <= r + 42; c++) push_abs(c, 2'b10, ((5 + c - r - 25) % 8) == 7, 1'b0);
        run_to(r + 2);
        i_switch = 4'b0001;
        run_to(r + 22);
        i_switch = 4'b0011;
        run_to(r + 40);

        // Back to IDLE, then start without resume: flush ends in HOLD.
        a = cyc;
        i_switch = 4'b0000;
        push_abs(a + 3, 2'b00, 1'b0, 1'b0);
        run_to(a + 3);
        i_switch = 4'b0001;
        f1 = cyc + 3;
        push_abs(cyc + 1, 2'b00, 1'b0, 1'b0);
        push_abs(cyc + 2, 2'b00, 1'b0, 1'b0);
        push_flush(f1, 64);
        push_abs(f1 + 64, 2'b11, 1'b0, 1'b0);
        push_abs(f1 + 65, 2'b11, 1'b0, 1'b0);
        run_to(f1 + 65);

        // Run switch dropped mid-flush: IDLE three edges later.
        i_switch = 4'b0000;
        push_abs(f1 + 66, 2'b11, 1'b0, 1'b0);
        push_abs(f1 + 67, 2'b11, 1'b0, 1'b0);
        push_abs(f1 + 68, 2'b00, 1'b0, 1'b0);
        run_to(f1 + 68);
        i_switch = 4'b0011;
        g = cyc + 3;
        push_abs(g - 2, 2'b00, 1'b0, 1'b0);
        push_abs(g - 1, 2'b00, 1'b0, 1'b0);
        push_flush(g, 23);
        push_abs(g + 23, 2'b00, 1'b0, 1'b0);
        run_to(g + 20);
        i_switch = 4'b0010;
        run_to(g + 23);

        // Re-entry flushes the full 64 clocks again.
        i_switch = 4'b0011;
        h = cyc + 3;
        push_abs(h - 2, 2'b00, 1'b0, 1'b0);
        push_abs(h - 1, 2'b00, 1'b0, 1'b0);
        push_flush(h, 64);
        push_abs(h + 64, 2'b10, 1'b0, 1'b0);
        run_to(h + 64);

        // Reset mid-flush: IDLE after one edge, synchroniser cleared too.
        i_switch = 4'b0000;
        push_abs(h + 67, 2'b00, 1'b0, 1'b0);
        run_to(h + 67);
        i_switch = 4'b0011;
        j = cyc + 3;
        push_flush(j, 31);
        for (int c = j + 31; c <= j + 35; c++) push_abs(c, 2'b00, 1'b0, 1'b0);
        run_to(j + 30);
        i_reset = 1'b0;
        run_to(j + 33);
        i_reset = 1'b1;

        // Fresh flush then a long RUN; the heartbeat toggles every 2048 clocks.
        k0 = j + 36;
        push_flush(k0, 64);
        for (int c = k0 + 64; c <= k0 + 4200; c++) begin
            push_abs(c, 2'b10, ((c - k0) % 8) == 7, (((c - k0) / 2048) % 2) == 1);
        end
        run_to(k0 + 4200);

        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
